// File: rtl/geofence_feeder_if.sv
// Stream, engine and result signals between the geofence feeder and its neighbours.
// master: the feeder. slave: upstream source, engine and result sink seen as one peer.
interface geofence_feeder_if #(
  parameter int unsigned CW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [9:0]    in_x;
  logic [9:0]    in_y;
  logic          gf_reset;
  logic [9:0]    X;
  logic [9:0]    Y;
  logic          valid;
  logic          is_inside;
  logic          res_valid;
  logic          res_ready;
  logic          res_inside;
  logic          res_timeout;
  logic [CW-1:0] case_cnt;
  logic [CW-1:0] inside_cnt;

  modport master (
    input  in_valid, in_x, in_y, valid, is_inside, res_ready,
    output in_ready, gf_reset, X, Y, res_valid, res_inside, res_timeout, case_cnt, inside_cnt
  );

  modport slave (
    output in_valid, in_x, in_y, valid, is_inside, res_ready,
    input  in_ready, gf_reset, X, Y, res_valid, res_inside, res_timeout, case_cnt, inside_cnt
  );
endinterface

// File: rtl/geofence_feeder.sv
// Buffers one geofence case, replays it to the engine serially and returns the verdict
// (or a timeout) downstream, keeping saturating case/inside counters.
module geofence_feeder #(
  parameter int unsigned NPTS    = 7,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CW      = 16
) (
  input logic               clk,
  input logic               reset,
  geofence_feeder_if.master bus
);
  localparam int unsigned PtrW = $clog2(NPTS);
  localparam int unsigned IdxW = $clog2(NPTS + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT);

  localparam logic [PtrW-1:0] LastPtr = PtrW'(NPTS - 1);
  localparam logic [IdxW-1:0] EndIdx  = IdxW'(NPTS);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);
  localparam logic [CW-1:0]   CntMax  = {CW{1'b1}};

  typedef enum logic [2:0] {StFill, StRst, StSend, StWait, StReport} state_e;

  state_e          state_q;
  logic [PtrW-1:0] wr_ptr_q;
  logic [IdxW-1:0] rd_idx_q;
  logic [TmoW-1:0] wait_cnt_q;
  logic [19:0]     pts_q [NPTS];

  // Buffer contents are deliberately not reset; a reset abandons them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StFill;
      wr_ptr_q        <= '0;
      rd_idx_q        <= '0;
      wait_cnt_q      <= '0;
      bus.in_ready    <= 1'b1;
      bus.gf_reset    <= 1'b0;
      bus.X           <= '0;
      bus.Y           <= '0;
      bus.res_valid   <= 1'b0;
      bus.res_inside  <= 1'b0;
      bus.res_timeout <= 1'b0;
      bus.case_cnt    <= '0;
      bus.inside_cnt  <= '0;
    end else begin
      unique case (state_q)
        StFill: begin
          if (bus.in_valid) begin
            pts_q[wr_ptr_q] <= {bus.in_x, bus.in_y};
            if (wr_ptr_q == LastPtr) begin
              wr_ptr_q     <= '0;
              bus.in_ready <= 1'b0;
              bus.gf_reset <= 1'b1;
              state_q      <= StRst;
            end else begin
              wr_ptr_q <= wr_ptr_q + 1'b1;
            end
          end
        end
        StRst: begin
          bus.gf_reset <= 1'b0;
          bus.X        <= pts_q[0][19:10];
          bus.Y        <= pts_q[0][9:0];
          rd_idx_q     <= IdxW'(1);
          state_q      <= StSend;
        end
        StSend: begin
          if (rd_idx_q == EndIdx) begin
            bus.X      <= '0;
            bus.Y      <= '0;
            wait_cnt_q <= '0;
            state_q    <= StWait;
          end else begin
            bus.X    <= pts_q[rd_idx_q[PtrW-1:0]][19:10];
            bus.Y    <= pts_q[rd_idx_q[PtrW-1:0]][9:0];
            rd_idx_q <= rd_idx_q + 1'b1;
          end
        end
        StWait: begin
          // A verdict on the last timeout cycle still wins over the abort.
          if (bus.valid) begin
            bus.res_valid   <= 1'b1;
            bus.res_inside  <= bus.is_inside;
            bus.res_timeout <= 1'b0;
            state_q         <= StReport;
          end else if (wait_cnt_q == TmoLast) begin
            bus.res_valid   <= 1'b1;
            bus.res_inside  <= 1'b0;
            bus.res_timeout <= 1'b1;
            state_q         <= StReport;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        StReport: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state_q       <= StFill;
            if (bus.case_cnt != CntMax) begin
              bus.case_cnt <= bus.case_cnt + 1'b1;
            end
            if (bus.res_inside && (bus.inside_cnt != CntMax)) begin
              bus.inside_cnt <= bus.inside_cnt + 1'b1;
            end
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end
endmodule

// File: tb/tb_geofence_feeder.sv
// Directed, table-driven bench for geofence_feeder with a scripted engine response.
module tb_geofence_feeder;
  localparam int NPTS    = 7;
  localparam int TIMEOUT = 64;
  localparam int CW      = 16;

  typedef struct {
    logic [6:0][9:0] px;
    logic [6:0][9:0] py;
    int              lat;    // WAIT cycle in which the engine pulses valid; >= TIMEOUT: never
    bit              ans;
    int              hold;   // cycles res_ready stays low in REPORT
    bit              exp_in;
    bit              exp_to;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   exp_case = 0;
  int   exp_inside = 0;
  vec_t tbl [5];

  always #5 clk = ~clk;

  geofence_feeder_if #(.CW(CW)) bus ();

  geofence_feeder #(
    .NPTS   (NPTS),
    .TIMEOUT(TIMEOUT),
    .CW     (CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  function automatic vec_t mk(input int tx, input int ty, input int lat, input bit ans,
                              input int hold, input bit ei, input bit eto);
    vec_t v;
    int hx [6] = '{300, 400, 600, 700, 600, 400};
    int hy [6] = '{500, 327, 327, 500, 673, 673};
    v.px[0] = 10'(tx);
    v.py[0] = 10'(ty);
    for (int i = 1; i < NPTS; i++) begin
      v.px[i] = 10'(hx[i-1]);
      v.py[i] = 10'(hy[i-1]);
    end
    v.lat    = lat;
    v.ans    = ans;
    v.hold   = hold;
    v.exp_in = ei;
    v.exp_to = eto;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feeds the 7 points; gapped mode drives in_valid 1,0,0 and pulses a stray engine valid.
  task automatic fill(input vec_t v, input bit gapped);
    int n;
    int cyc;
    bit drv;
    n   = 0;
    cyc = 0;
    chk("fill_in_ready", bus.in_ready, 1);
    while (n < NPTS) begin
      drv           = !gapped || (cyc % 3 == 0);
      bus.in_valid  = drv;
      bus.in_x      = v.px[n];
      bus.in_y      = v.py[n];
      bus.valid     = gapped && !drv;
      bus.is_inside = 1'b1;
      tick();
      if (drv) n++;
      cyc++;
      if (gapped && n < NPTS) begin
        chk($sformatf("gap_ready[%0d]", cyc), bus.in_ready, 1);
        chk($sformatf("gap_no_rst[%0d]", cyc), bus.gf_reset, 0);
      end
    end
    bus.in_valid  = 1'b0;
    bus.valid     = 1'b0;
    bus.is_inside = 1'b0;
    chk("rst_pulse", bus.gf_reset, 1);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_x", bus.X, 0);
  endtask

  task automatic send_and_finish(input vec_t v);
    int w;
    int exp_w;
    for (int k = 0; k < NPTS; k++) begin
      tick();
      chk($sformatf("x[%0d]", k), bus.X, v.px[k]);
      chk($sformatf("y[%0d]", k), bus.Y, v.py[k]);
      chk($sformatf("send_rst[%0d]", k), bus.gf_reset, 0);
    end
    tick();
    chk("wait_x", bus.X, 0);
    chk("wait_y", bus.Y, 0);
    w = 0;
    while (1) begin
      bus.valid     = (w == v.lat);
      bus.is_inside = (w == v.lat) ? v.ans : 1'b0;
      tick();
      bus.valid     = 1'b0;
      bus.is_inside = 1'b0;
      if (bus.res_valid) break;
      w++;
      if (w > 2 * TIMEOUT) begin
        checks++;
        errors++;
        $display("FAIL wait_bound: res_valid absent after %0d cycles, expected by %0d", w, TIMEOUT);
        break;
      end
    end
    exp_w = (v.lat < TIMEOUT) ? v.lat : TIMEOUT - 1;
    chk("wait_len", w, exp_w);
    chk("res_valid", bus.res_valid, 1);
    chk("res_inside", bus.res_inside, v.exp_in);
    chk("res_timeout", bus.res_timeout, v.exp_to);
    chk("rep_case_cnt", bus.case_cnt, exp_case);
    bus.in_valid = 1'b1;
    bus.in_x     = 10'd123;
    bus.in_y     = 10'd456;
    for (int h = 0; h < v.hold; h++) begin
      tick();
      chk($sformatf("bp_valid[%0d]", h), bus.res_valid, 1);
      chk($sformatf("bp_inside[%0d]", h), bus.res_inside, v.exp_in);
      chk($sformatf("bp_timeout[%0d]", h), bus.res_timeout, v.exp_to);
      chk($sformatf("bp_in_ready[%0d]", h), bus.in_ready, 0);
      chk($sformatf("bp_case_cnt[%0d]", h), bus.case_cnt, exp_case);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    bus.in_valid  = 1'b0;
    if (exp_case < (1 << CW) - 1) exp_case++;
    if (v.exp_in && exp_inside < (1 << CW) - 1) exp_inside++;
    chk("hs_res_valid", bus.res_valid, 0);
    chk("hs_in_ready", bus.in_ready, 1);
    chk("hs_case_cnt", bus.case_cnt, exp_case);
    chk("hs_inside_cnt", bus.inside_cnt, exp_inside);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t g;
    tbl[0] = mk(500, 500, 12, 1'b1, 0, 1'b1, 1'b0);   // inside
    tbl[1] = mk(900, 100, 3, 1'b0, 20, 1'b0, 1'b0);   // outside, backpressure
    tbl[2] = mk(500, 500, 999, 1'b1, 2, 1'b0, 1'b1);  // engine silent: timeout
    tbl[3] = mk(500, 500, 63, 1'b1, 1, 1'b1, 1'b0);   // verdict on the final timeout cycle
    tbl[4] = mk(0, 500, 0, 1'b0, 0, 1'b0, 1'b0);      // immediate verdict, X=0 passes through

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.valid     = 1'b0;
    bus.is_inside = 1'b0;
    bus.res_ready = 1'b0;
    repeat (2) tick();
    chk("rst_in_ready0", bus.in_ready, 1);
    chk("rst_gf_reset0", bus.gf_reset, 0);
    chk("rst_x0", bus.X, 0);
    chk("rst_res_valid0", bus.res_valid, 0);
    chk("rst_case_cnt0", bus.case_cnt, 0);
    chk("rst_inside_cnt0", bus.inside_cnt, 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      fill(tbl[i], 1'b0);
      send_and_finish(tbl[i]);
    end

    // Gapped input with a stray verdict strobe during FILL.
    g = mk(900, 100, 5, 1'b0, 0, 1'b0, 1'b0);
    fill(g, 1'b1);
    send_and_finish(g);

    // Reset while index 3 is on the engine bus.
    fill(tbl[0], 1'b0);
    repeat (4) tick();
    chk("send3_x", bus.X, tbl[0].px[3]);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_x", bus.X, 0);
    chk("mid_rst_y", bus.Y, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    chk("mid_rst_gf_reset", bus.gf_reset, 0);
    chk("mid_rst_res_valid", bus.res_valid, 0);
    chk("mid_rst_case_cnt", bus.case_cnt, 0);
    chk("mid_rst_inside_cnt", bus.inside_cnt, 0);
    exp_case   = 0;
    exp_inside = 0;
    fill(tbl[0], 1'b0);
    send_and_finish(tbl[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/geofence_feeder.md
Name: geofence_feeder

Overview:
- Initiator-side driver for the geofence engine.
- Accepts one test case (target point plus 6 fence vertices) from an upstream ready/valid stream and buffers it.
- Replays the case to the engine on its serial X/Y interface, waits for the engine's valid/is_inside pulse, and returns the verdict downstream with a ready/valid handshake.
- Keeps running case and inside counters.

Parameters:
- NPTS, 7, points per case: index 0 is the target, indices 1..6 are fence vertices.
- TIMEOUT, 64, maximum cycles in WAIT before the case is aborted.
- CW, 16, width of the case_cnt and inside_cnt counters.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high; one clock and synchronous active-high reset are fixed for this block.
- in_valid  in  1  upstream point valid.
- in_ready  out  1  upstream point accept.
- in_x  in  10  upstream point X.
- in_y  in  10  upstream point Y.
- gf_reset  out  1  engine reset pulse, registered.
- X  out  10  engine point X, registered.
- Y  out  10  engine point Y, registered.
- valid  in  1  engine verdict strobe.
- is_inside  in  1  engine verdict, meaningful only while valid=1.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accept.
- res_inside  out  1  verdict of the case: 1 = target inside the fence.
- res_timeout  out  1  case aborted, no engine verdict received.
- case_cnt  out  CW  number of completed cases, saturating.
- inside_cnt  out  CW  number of cases with res_inside=1, saturating.

Behaviour:

Reset:
- Synchronous reset values: state=FILL, write pointer=0, in_ready=1, gf_reset=0, X=0, Y=0, res_valid=0, res_inside=0, res_timeout=0, case_cnt=0, inside_cnt=0.
- Reset mid-operation abandons the case and the buffer contents.

Buffer:
- NPTS x 20-bit registers, written in arrival order.

FSM (one-hot or binary, implementer's choice):
- FILL:
  - in_ready=1.
  - Each cycle with in_valid=1, store {in_x,in_y} at the write pointer and increment it.
  - When the point at index NPTS-1 is accepted, clear the pointer and go to RST.
  - in_ready is 0 in every other state.
- RST:
  - Exactly one cycle with gf_reset=1; X=Y=0.
  - Next state is SEND with read index 0.
- SEND:
  - NPTS consecutive cycles.
  - In cycle k, X/Y show buffer[k]: target first, then vertices 1..6, with no gaps.
  - After index NPTS-1 go to WAIT.
  - Values are forwarded unmodified, including X=0 (the engine treats X=0 as empty; producing such points is upstream's responsibility).
- WAIT:
  - X=Y=0 and a cycle counter runs.
  - If valid=1: capture is_inside into res_inside, set res_timeout=0, go to REPORT.
  - Else if the counter reaches TIMEOUT-1: set res_inside=0 and res_timeout=1, go to REPORT.
  - If valid arrives in the same cycle the counter expires, valid wins.
- REPORT:
  - res_valid=1; res_inside and res_timeout are held stable until res_ready=1.
  - On the handshake cycle: res_valid drops next cycle, case_cnt increments, inside_cnt increments if res_inside=1, and the FSM returns to FILL.
  - Both counters saturate at all-ones; no wrap.

Engine interface rules:
- The engine must not see X/Y changes outside SEND.
- A valid received outside WAIT is ignored and has no effect on counters or state.
- gf_reset is asserted only in RST, so every case starts from a freshly reset engine, even though the engine's own valid also clears it.

Latency:
- Case cycles = 7 accepted input cycles + 1 (RST) + 7 (SEND) + engine latency + at least 1 (REPORT).
- First X/Y is presented 2 cycles after the 7th point is accepted.

Upstream stalls:
- in_valid low during FILL simply pauses filling.
- Partial cases persist indefinitely until completed or reset.

Test Plan:
1. Inside case:
   - Stimulus: target (500,500); vertices (300,500), (400,327), (600,327), (700,500), (600,673), (400,673); engine model answers is_inside=1 after 12 cycles.
   - Required: gf_reset pulse 1 cycle after the 7th accept; X sequence 500,300,400,600,700,600,400; res_valid with res_inside=1, res_timeout=0; case_cnt=1, inside_cnt=1.
2. Outside case:
   - Stimulus: same hexagon, target (900,100); model answers 0 after 3 cycles.
   - Required: res_inside=0; inside_cnt unchanged; case_cnt increments.
3. Backpressure:
   - Stimulus: hold res_ready=0 for 20 cycles in REPORT, with in_valid=1 throughout.
   - Required: res_* stable; in_ready=0; no counter change until the handshake; FILL resumes on the next cycle.
4. Timeout:
   - Stimulus: model never asserts valid.
   - Required: res_valid exactly TIMEOUT cycles after WAIT entry, with res_timeout=1, res_inside=0.
   - Stimulus: valid on the final timeout cycle.
   - Required: the verdict is taken and res_timeout=0.
5. Gapped input / spurious valid:
   - Stimulus: in_valid toggling 1,0,0,1…; valid pulsed during FILL.
   - Required: exactly 7 accepted points; the stray valid is ignored.
6. Reset during SEND at index 3:
   - Required: the next cycle shows all reset values (X=Y=0, in_ready=1, counters 0).
   - Required: a following full case completes normally.
